uart_tx_queue: RTL and testbench

Transmit-side feed stage that sits directly upstream of the UART transmitter inside `top_uart`. It accepts bytes from a producer over a valid/ready handshake and buffers them in a small FIFO. It then hands the bytes one at a time to the transmitter using a start-pulse / busy handshake, so the producer never has to track line timing.

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_sync_fifo.sv | 60 ++++++
 rtl/uart_tx_queue.sv | 112 +++++++++++
 tb/tb_uart_tx_queue.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | uart_pkg : shared types and defaults for the UART transmit feed path  |
// | Revision : 1.0                                                        |
// +-----------------------------------------------------------------------+
package uart_pkg;

  localparam int UART_DATA_W  = 8;
  localparam int TXQ_ACK_WAIT = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    ACK   = 2'd2,
    SEND  = 2'd3
  } txq_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_sync_fifo.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | uart_sync_fifo : single-clock FIFO with occupancy count and clear     |
// | Revision       : 1.0                                                  |
// +-----------------------------------------------------------------------+
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr_i,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [WIDTH-1:0]       wdata_i,
  output logic [WIDTH-1:0]       rdata_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
  output logic                   empty_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wptr_q, rptr_q;
  logic [PTR_W:0]   count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o && !clr_i;
  assign do_pop  = pop_i && !empty_o && !clr_i;
  assign rdata_o = mem_q[rptr_q];
  assign count_o = count_q;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wptr_q] <= wdata_i;
    end
  end

  // Power-of-two depth lets the pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + PTR_W'(1);
      if (do_pop)  rptr_q <= rptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (PTR_W+1)'(1);
        2'b01:   count_q <= count_q - (PTR_W+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx_queue.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | uart_tx_queue : buffers producer bytes and feeds the UART transmitter |
// | Revision      : 1.0                                                   |
// +-----------------------------------------------------------------------+
module uart_tx_queue
  import uart_pkg::*;
#(
  parameter int DATA_W   = UART_DATA_W,
  parameter int DEPTH    = 8,
  parameter int ACK_WAIT = TXQ_ACK_WAIT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_W-1:0]        in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     flush,
  output logic [DATA_W-1:0]        tx_data,
  output logic                     tx_start,
  input  logic                     tx_busy,
  output logic                     tx_done,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     err_no_ack
);

  localparam int CNT_W  = $clog2(DEPTH) + 1;
  localparam int WAIT_W = (ACK_WAIT < 2) ? 1 : $clog2(ACK_WAIT + 1);

  txq_state_t          state_q, state_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic [DATA_W-1:0]   tx_data_q;
  logic                tx_done_q, tx_done_d;
  logic                err_q;

  logic [DATA_W-1:0]   fifo_rdata;
  logic [CNT_W-1:0]    fifo_count;
  logic                fifo_full, fifo_empty;
  logic                push, pop, ack_expired;

  assign in_ready = !rst && !flush && !fifo_full;
  assign push     = in_valid && in_ready;

  uart_sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (flush),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (in_data),
    .rdata_o (fifo_rdata),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // The last permitted ACK cycle without busy is the one that expires the wait.
  assign ack_expired = (state_q == ACK) && !tx_busy && (wait_q <= WAIT_W'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      wait_q    <= '0;
      tx_data_q <= '0;
      tx_done_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      tx_done_q <= tx_done_d;
      err_q     <= err_q | ack_expired;
      if (pop) tx_data_q <= fifo_rdata;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (pop) state_d = START;
      START:   state_d = ACK;
      ACK: begin
        if (tx_busy)          state_d = SEND;
        else if (ack_expired) state_d = IDLE;
      end
      SEND:    if (!tx_busy) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A flush in the same cycle as a pending pop wins: the head stays put.
  always_comb begin
    pop       = (state_q == IDLE) && !fifo_empty && !flush;
    tx_start  = (state_q == START);
    tx_done_d = ack_expired || ((state_q == SEND) && !tx_busy);
    wait_d    = wait_q;
    if (state_q == START) begin
      wait_d = WAIT_W'(ACK_WAIT);
    end else if ((state_q == ACK) && !tx_busy && (wait_q != '0)) begin
      wait_d = wait_q - WAIT_W'(1);
    end
  end

  assign tx_data    = tx_data_q;
  assign tx_done    = tx_done_q;
  assign count      = fifo_count;
  assign err_no_ack = err_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_queue.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_uart_tx_queue : self-checking bench for the UART transmit queue    |
// | Revision         : 1.0                                                |
// +-----------------------------------------------------------------------+
module tb_uart_tx_queue;

  localparam int DATA_W   = 8;
  localparam int DEPTH    = 8;
  localparam int ACK_WAIT = 4;
  localparam int CNT_W    = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic [DATA_W-1:0] tx_data;
  logic              tx_start;
  logic              tx_busy = 1'b0;
  logic              tx_done;
  logic [CNT_W-1:0]  count;
  logic              err_no_ack;

  always #5 clk = ~clk;

  uart_tx_queue #(
    .DATA_W   (DATA_W),
    .DEPTH    (DEPTH),
    .ACK_WAIT (ACK_WAIT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .flush      (flush),
    .tx_data    (tx_data),
    .tx_start   (tx_start),
    .tx_busy    (tx_busy),
    .tx_done    (tx_done),
    .count      (count),
    .err_no_ack (err_no_ack)
  );

  int passed = 0;
  int total  = 0;
  logic [DATA_W-1:0] sb[$];
  int done_cnt  = 0;
  int start_cnt = 0;
  bit ack_en    = 1'b1;
  int busy_len  = 3;
  int rem       = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: actual %0h required %0h", name, act, exp);
    else passed++;
  endtask

  // Transmitter stand-in: answers tx_start with busy for busy_len cycles.
  always @(posedge clk) begin
    #1;
    if (rst) begin
      tx_busy = 1'b0;
      rem     = 0;
    end else if (tx_start && ack_en) begin
      tx_busy = 1'b1;
      rem     = busy_len;
    end else if (rem > 0) begin
      rem--;
      if (rem == 0) tx_busy = 1'b0;
    end
  end

  // Scoreboard: every launched byte must be the oldest accepted one.
  always @(negedge clk) begin
    if (tx_start) begin
      start_cnt++;
      chk("sb_has_byte", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) chk("tx_data_order", 32'(tx_data), 32'(sb.pop_front()));
    end
    if (rst || flush) sb.delete();
    if (tx_done) done_cnt++;
  end

  task automatic cyc(input logic r, input logic f, input logic v, input logic [7:0] d, output bit acc);
    rst = r; flush = f; in_valid = v; in_data = d;
    #1;
    acc = v && in_ready;
    if (acc) sb.push_back(d);
    @(posedge clk); #2;
  endtask

  task automatic idle(input int n);
    bit a;
    repeat (n) cyc(1'b0, 1'b0, 1'b0, 8'h00, a);
  endtask

  task automatic push(input logic [7:0] d);
    bit a;
    int k;
    k = 0;
    do begin
      cyc(1'b0, 1'b0, 1'b1, d, a);
      k++;
    end while (!a && k < 200);
    chk("push_accepted", 32'(a), 32'd1);
  endtask

  task automatic do_reset();
    bit a;
    cyc(1'b1, 1'b0, 1'b0, 8'h00, a);
    cyc(1'b1, 1'b0, 1'b0, 8'h00, a);
  endtask

  task automatic wait_done(input int target, input int budget);
    int k;
    k = 0;
    while (done_cnt < target && k < budget) begin
      idle(1);
      k++;
    end
    chk("done_within_budget", 32'(done_cnt >= target), 32'd1);
  endtask

  typedef struct {
    logic       r, f, v;
    logic [7:0] d;
    logic       e_rdy;
    logic [3:0] e_cnt;
    logic       e_start, e_done;
  } vec_t;

  vec_t tbl[13];

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit a;
    int d0, s0, k;

    //            r  f  v  data    rdy cnt st dn
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 4'd0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b0, 1'b1, 8'hA5, 1'b1, 4'd0, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 4'd1, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 4'd0, 1'b1, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 4'd0, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 4'd0, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 4'd0, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 4'd0, 1'b0, 1'b1};
    tbl[8]  = '{1'b0, 1'b1, 1'b1, 8'h3C, 1'b0, 4'd0, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 1'b1, 8'h5A, 1'b1, 4'd0, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 4'd1, 1'b0, 1'b0};
    tbl[11] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 4'd0, 1'b1, 1'b0};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 4'd0, 1'b0, 1'b0};

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0;
    @(posedge clk); #2;
    cyc(1'b1, 1'b0, 1'b0, 8'h00, a);
    chk("reset_tx_data", 32'(tx_data), 32'h0);
    chk("reset_err", 32'(err_no_ack), 32'd0);

    busy_len = 3;
    for (int i = 0; i < 13; i++) begin
      chk($sformatf("tbl%0d_count", i), 32'(count), 32'(tbl[i].e_cnt));
      chk($sformatf("tbl%0d_start", i), 32'(tx_start), 32'(tbl[i].e_start));
      chk($sformatf("tbl%0d_done", i), 32'(tx_done), 32'(tbl[i].e_done));
      rst = tbl[i].r; flush = tbl[i].f; in_valid = tbl[i].v; in_data = tbl[i].d;
      #1;
      chk($sformatf("tbl%0d_ready", i), 32'(in_ready), 32'(tbl[i].e_rdy));
      if (tbl[i].v && in_ready) sb.push_back(tbl[i].d);
      @(posedge clk); #2;
    end

    // Single byte with a 10-cycle frame
    busy_len = 10;
    do_reset();
    d0 = done_cnt;
    push(8'hA5);
    idle(5);
    chk("single_data_held", 32'(tx_data), 32'hA5);
    wait_done(d0 + 1, 60);
    idle(3);
    chk("single_done_once", 32'(done_cnt - d0), 32'd1);
    chk("single_count", 32'(count), 32'd0);

    // Fill to full while the first byte is in flight
    busy_len = 40;
    do_reset();
    d0 = done_cnt;
    for (int b = 1; b <= 9; b++) push(8'(b));
    chk("fill_count8", 32'(count), 32'd8);
    for (int j = 0; j < 3; j++) begin
      cyc(1'b0, 1'b0, 1'b1, 8'h0A, a);
      chk("fill_refused", 32'(a), 32'd0);
    end
    push(8'h0A);
    wait_done(d0 + 10, 600);
    chk("fill_sb_empty", 32'(sb.size()), 32'd0);
    chk("fill_count0", 32'(count), 32'd0);

    // Push coinciding with pop at count 3
    busy_len = 6;
    do_reset();
    d0 = done_cnt;
    push(8'h20); push(8'h21); push(8'h22); push(8'h23);
    k = 0;
    while (!tx_done && k < 50) begin
      idle(1);
      k++;
    end
    chk("pp_done_seen", 32'(tx_done), 32'd1);
    chk("pp_count_before", 32'(count), 32'd3);
    cyc(1'b0, 1'b0, 1'b1, 8'h24, a);
    chk("pp_push_acc", 32'(a), 32'd1);
    chk("pp_count_after", 32'(count), 32'd3);
    chk("pp_start", 32'(tx_start), 32'd1);
    wait_done(d0 + 5, 200);
    chk("pp_sb_empty", 32'(sb.size()), 32'd0);

    // Flush with one byte in flight
    busy_len = 8;
    do_reset();
    d0 = done_cnt; s0 = start_cnt;
    push(8'h10); push(8'h11); push(8'h12);
    cyc(1'b0, 1'b1, 1'b0, 8'h00, a);
    chk("flush_count", 32'(count), 32'd0);
    idle(40);
    chk("flush_done_one", 32'(done_cnt - d0), 32'd1);
    chk("flush_start_one", 32'(start_cnt - s0), 32'd1);

    // Transmitter never acknowledges
    ack_en = 1'b0;
    do_reset();
    d0 = done_cnt;
    push(8'h55); push(8'h66);
    k = 0;
    while (!tx_start && k < 10) begin
      idle(1);
      k++;
    end
    chk("noack_start", 32'(tx_start), 32'd1);
    for (int j = 1; j <= 4; j++) begin
      idle(1);
      chk($sformatf("noack_wait%0d", j), 32'(err_no_ack), 32'd0);
    end
    idle(1);
    chk("noack_err", 32'(err_no_ack), 32'd1);
    chk("noack_done", 32'(tx_done), 32'd1);
    idle(1);
    chk("noack_next_start", 32'(tx_start), 32'd1);
    wait_done(d0 + 2, 50);
    chk("noack_sticky", 32'(err_no_ack), 32'd1);
    ack_en = 1'b1;

    // Reset in the middle of a frame with two bytes queued
    busy_len = 20;
    do_reset();
    push(8'h30); push(8'h31); push(8'h32);
    idle(3);
    chk("rst_mid_count2", 32'(count), 32'd2);
    cyc(1'b1, 1'b0, 1'b0, 8'h00, a);
    chk("rst_mid_count", 32'(count), 32'd0);
    chk("rst_mid_start", 32'(tx_start), 32'd0);
    chk("rst_mid_done", 32'(tx_done), 32'd0);
    chk("rst_mid_data", 32'(tx_data), 32'h0);
    chk("rst_mid_err", 32'(err_no_ack), 32'd0);
    rst = 1'b0; in_valid = 1'b0;
    #1;
    chk("rst_mid_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #2;
    s0 = start_cnt; d0 = done_cnt;
    idle(20);
    chk("rst_mid_no_start", 32'(start_cnt - s0), 32'd0);
    push(8'h40);
    wait_done(d0 + 1, 60);
    chk("rst_mid_new_start", 32'(start_cnt - s0), 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
